encoded_capture: RTL and testbench
==================================

ENCODED_CAPTURE -- requirements
Module: encoded_capture

Interface
REQ-001 Parameter DEPTH, default 32640: capture buffer size in bytes.
REQ-002 Parameter AW, default 15: address/count width; SHALL satisfy 2^AW >= DEPTH+1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clear  input  1  reset, synchronous and active-high.
REQ-005 we  input  1  producer write strobe; one byte valid per high cycle.
REQ-006 dataEncoded  input  8  encoded byte from producer, qualified by we.
REQ-007 finallydone  input  1  producer end-of-stream flag.
REQ-008 rd_en  input  1  readback request.
REQ-009 rd_addr  input  AW  readback byte address.
REQ-010 rd_data  output  8  readback byte, registered.
REQ-011 rd_valid  output  1  rd_data qualifier, one-cycle pulse.
REQ-012 byte_count  output  AW  bytes stored.
REQ-013 checksum  output  16  running sum of accepted bytes.
REQ-014 overflow  output  1  sticky; a byte arrived with buffer full.
REQ-015 capture_done  output  1  high while in DONE.

Function
REQ-016 FSM states SHALL be IDLE, CAPTURE, DONE, encoded in a registered state variable.
REQ-017 IDLE: we=1 -> byte stored at address 0, go CAPTURE; finallydone=1 (we=0) -> go DONE with byte_count 0.
REQ-018 CAPTURE: each we=1 cycle stores dataEncoded at address byte_count, byte_count += 1, checksum += zero-extended byte.
REQ-019 CAPTURE: finallydone=1 -> go DONE next cycle.
REQ-020 we and finallydone high in the same cycle (any state except DONE): byte SHALL be accepted, then DONE.
REQ-021 Full (byte_count == DEPTH) and we=1: byte dropped, byte_count and checksum unchanged, overflow set and held until clear.
REQ-022 checksum SHALL wrap modulo 2^16; no saturation.
REQ-023 DONE: we and finallydone ignored; state held until clear; capture_done=1.
REQ-024 Readback accepted only in DONE: rd_en=1 -> next cycle rd_valid=1, rd_data = buffer[rd_addr].
REQ-025 rd_addr >= byte_count: rd_data SHALL be 8'h00, rd_valid still 1.
REQ-026 rd_en outside DONE ignored; rd_valid stays 0.
REQ-027 Back-to-back rd_en SHALL give one rd_valid per request, latency exactly 1 cycle, full throughput.
REQ-028 Write latency: byte presented in cycle N is readable by rd_en issued in cycle N+1 or later.
REQ-029 Buffer SHALL be a single-write, single-read synchronous memory inferable as block RAM; no content reset.

Reset
REQ-030 clear=1 at a rising edge: state IDLE, byte_count 0, checksum 0, overflow 0, capture_done 0, rd_valid 0, rd_data 8'h00.
REQ-031 clear takes priority over we, finallydone, rd_en in the same cycle; byte present that cycle is not stored.
REQ-032 clear mid-CAPTURE or mid-readback SHALL abort cleanly; buffer contents undefined thereafter but never exposed (byte_count 0).

Verification
REQ-033 clear; bytes 0x11,0x22,0x33 on 3 we cycles; finallydone -> capture_done=1, byte_count 3, checksum 0x0066; reads addr 0..2 return 0x11,0x22,0x33, each rd_valid one cycle after rd_en.
REQ-034 we=1 with 0xAB and finallydone=1 in same cycle from IDLE -> DONE, byte_count 1, checksum 0x00AB, read addr 0 = 0xAB.
REQ-035 DEPTH=4 build: 6 bytes 0xFF -> byte_count 4, checksum 0x03FC, overflow=1; read addr 4 -> rd_data 0x00, rd_valid 1.
REQ-036 300 bytes 0xFF -> checksum 0x2AD4 (76500 mod 65536), byte_count 300.
REQ-037 clear asserted after 2 of 5 bytes -> outputs at reset values next cycle; we pulses during/after IDLE start fresh capture at address 0.
REQ-038 rd_en during CAPTURE -> rd_valid stays 0; finallydone with no prior we -> DONE, byte_count 0, checksum 0.

Source files
------------

// File: rtl/encoded_capture.sv
// Captures a stream of encoded bytes into an on-chip buffer with a running checksum,
// then serves single-cycle-latency readback once the producer signals end of stream.
module encoded_capture #(
  parameter int DEPTH = 32640,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          we,
  input  logic [7:0]    dataEncoded,
  input  logic          finallydone,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [AW-1:0] byte_count,
  output logic [15:0]   checksum,
  output logic          overflow,
  output logic          capture_done
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   byte_count_r;
  logic [15:0]     checksum_r;
  logic            overflow_r;
  logic            capture_done_r;
  logic            rd_valid_r;
  logic [7:0]      rd_data_r;
  logic [7:0]      mem_r [0:DEPTH-1];

  logic            busy_s;
  logic            full_s;
  logic            wr_en_s;
  logic            drop_s;
  logic            rd_accept_s;
  logic            rd_hit_s;
  logic [IW-1:0]   wr_idx_s;
  logic [IW-1:0]   rd_idx_s;

  // Write/read qualification; clear blocks every side effect in its cycle
  always_comb begin
    busy_s      = (state_r != ST_DONE);
    full_s      = (byte_count_r == AW'(DEPTH));
    wr_en_s     = !clear && we && busy_s && !full_s;
    drop_s      = !clear && we && busy_s && full_s;
    rd_accept_s = !clear && rd_en && (state_r == ST_DONE);
    rd_hit_s    = (rd_addr < byte_count_r);
    wr_idx_s    = byte_count_r[IW-1:0];
    rd_idx_s    = rd_addr[IW-1:0];
  end

  // Buffer storage: one write port, one registered read port with synchronous zeroing
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= dataEncoded;
    end
    if (clear || (rd_accept_s && !rd_hit_s)) begin
      rd_data_r <= 8'h00;
    end else if (rd_accept_s) begin
      rd_data_r <= mem_r[rd_idx_s];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  // Capture FSM, counters, checksum and sticky flags
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r        <= ST_IDLE;
      byte_count_r   <= {AW{1'b0}};
      checksum_r     <= 16'h0000;
      overflow_r     <= 1'b0;
      capture_done_r <= 1'b0;
      rd_valid_r     <= 1'b0;
    end else begin
      rd_valid_r <= rd_accept_s;
      if (wr_en_s) begin
        byte_count_r <= byte_count_r + AW'(1);
        checksum_r   <= checksum_r + {8'h00, dataEncoded};
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (finallydone) begin
            state_r        <= ST_DONE;
            capture_done_r <= 1'b1;
          end else if (we) begin
            state_r <= ST_CAPTURE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          if (finallydone) begin
            state_r        <= ST_DONE;
            capture_done_r <= 1'b1;
          end else begin
            state_r <= ST_CAPTURE;
          end
        end
        ST_DONE: begin
          state_r        <= ST_DONE;
          capture_done_r <= 1'b1;
        end
        default: begin
          state_r        <= ST_IDLE;
          capture_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data      = rd_data_r;
  assign rd_valid     = rd_valid_r;
  assign byte_count   = byte_count_r;
  assign checksum     = checksum_r;
  assign overflow     = overflow_r;
  assign capture_done = capture_done_r;

endmodule

// File: tb/tb_encoded_capture.sv
// Directed bench for encoded_capture: default-depth instance plus a DEPTH=4 instance for overflow.
module tb_encoded_capture;

  logic        clk;
  int          checks;
  int          failures;

  logic        clear, we, finallydone, rd_en;
  logic [7:0]  dataEncoded;
  logic [14:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [14:0] byte_count;
  logic [15:0] checksum;
  logic        overflow, capture_done;

  logic        s_clear, s_we, s_finallydone, s_rd_en;
  logic [7:0]  s_data;
  logic [2:0]  s_rd_addr;
  logic [7:0]  s_rd_data;
  logic        s_rd_valid;
  logic [2:0]  s_byte_count;
  logic [15:0] s_checksum;
  logic        s_overflow, s_capture_done;

  encoded_capture u_dut (
    .clk(clk), .clear(clear), .we(we), .dataEncoded(dataEncoded),
    .finallydone(finallydone), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .byte_count(byte_count),
    .checksum(checksum), .overflow(overflow), .capture_done(capture_done)
  );

  encoded_capture #(.DEPTH(4), .AW(3)) u_small (
    .clk(clk), .clear(s_clear), .we(s_we), .dataEncoded(s_data),
    .finallydone(s_finallydone), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .byte_count(s_byte_count),
    .checksum(s_checksum), .overflow(s_overflow), .capture_done(s_capture_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b);
    we = 1'b1; dataEncoded = b; tick(); we = 1'b0;
  endtask

  task automatic finish_stream();
    finallydone = 1'b1; tick(); finallydone = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [14:0] a, input logic [7:0] exp);
    rd_en = 1'b1; rd_addr = a; tick(); rd_en = 1'b0;
    check_val({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check_val({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  task automatic s_read_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    s_rd_en = 1'b1; s_rd_addr = a; tick(); s_rd_en = 1'b0;
    check_val({tag, "_valid"}, 32'(s_rd_valid), 32'd1);
    check_val({tag, "_data"}, 32'(s_rd_data), 32'(exp));
  endtask

  initial begin
    checks = 0; failures = 0;
    clear = 1'b1; we = 1'b0; finallydone = 1'b0; rd_en = 1'b0;
    dataEncoded = 8'h00; rd_addr = 15'd0;
    s_clear = 1'b1; s_we = 1'b0; s_finallydone = 1'b0; s_rd_en = 1'b0;
    s_data = 8'h00; s_rd_addr = 3'd0;
    tick(); tick();
    clear = 1'b0; s_clear = 1'b0;

    check_val("rst_done", 32'(capture_done), 32'd0);
    check_val("rst_count", 32'(byte_count), 32'd0);
    check_val("rst_csum", 32'(checksum), 32'd0);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    check_val("rst_rvalid", 32'(rd_valid), 32'd0);
    check_val("rst_rdata", 32'(rd_data), 32'd0);

    // three-byte capture and back-to-back readback
    put_byte(8'h11); put_byte(8'h22); put_byte(8'h33);
    check_val("cap_notdone", 32'(capture_done), 32'd0);
    finish_stream();
    check_val("t1_done", 32'(capture_done), 32'd1);
    check_val("t1_count", 32'(byte_count), 32'd3);
    check_val("t1_csum", 32'(checksum), 32'h0066);
    rd_en = 1'b1;
    rd_addr = 15'd0; tick();
    check_val("b2b0_valid", 32'(rd_valid), 32'd1);
    check_val("b2b0_data", 32'(rd_data), 32'h11);
    rd_addr = 15'd1; tick();
    check_val("b2b1_valid", 32'(rd_valid), 32'd1);
    check_val("b2b1_data", 32'(rd_data), 32'h22);
    rd_addr = 15'd2; tick();
    check_val("b2b2_valid", 32'(rd_valid), 32'd1);
    check_val("b2b2_data", 32'(rd_data), 32'h33);
    rd_addr = 15'd3; tick();
    check_val("oob_valid", 32'(rd_valid), 32'd1);
    check_val("oob_data", 32'(rd_data), 32'h00);
    rd_en = 1'b0; tick();
    check_val("rd_idle_valid", 32'(rd_valid), 32'd0);
    put_byte(8'h55);
    check_val("done_ign_count", 32'(byte_count), 32'd3);
    check_val("done_ign_csum", 32'(checksum), 32'h0066);

    // simultaneous we + finallydone from IDLE
    do_clear();
    check_val("clr_done", 32'(capture_done), 32'd0);
    check_val("clr_count", 32'(byte_count), 32'd0);
    we = 1'b1; finallydone = 1'b1; dataEncoded = 8'hAB; tick();
    we = 1'b0; finallydone = 1'b0;
    check_val("t2_done", 32'(capture_done), 32'd1);
    check_val("t2_count", 32'(byte_count), 32'd1);
    check_val("t2_csum", 32'(checksum), 32'h00AB);
    read_chk("t2_rd0", 15'd0, 8'hAB);

    // clear mid-capture, byte present with clear is dropped
    do_clear();
    put_byte(8'h01); put_byte(8'h02);
    clear = 1'b1; we = 1'b1; dataEncoded = 8'h03; rd_en = 1'b1; tick();
    clear = 1'b0; we = 1'b0; rd_en = 1'b0;
    check_val("abort_count", 32'(byte_count), 32'd0);
    check_val("abort_csum", 32'(checksum), 32'd0);
    check_val("abort_done", 32'(capture_done), 32'd0);
    check_val("abort_rvalid", 32'(rd_valid), 32'd0);
    put_byte(8'h44); put_byte(8'h55);
    finish_stream();
    check_val("t3_count", 32'(byte_count), 32'd2);
    check_val("t3_csum", 32'(checksum), 32'h0099);
    read_chk("t3_rd0", 15'd0, 8'h44);
    read_chk("t3_rd1", 15'd1, 8'h55);

    // readback ignored outside DONE; empty stream
    do_clear();
    put_byte(8'h10);
    rd_en = 1'b1; rd_addr = 15'd0; tick(); rd_en = 1'b0;
    check_val("cap_rd_ign", 32'(rd_valid), 32'd0);
    do_clear();
    finish_stream();
    check_val("empty_done", 32'(capture_done), 32'd1);
    check_val("empty_count", 32'(byte_count), 32'd0);
    check_val("empty_csum", 32'(checksum), 32'd0);
    read_chk("empty_rd0", 15'd0, 8'h00);

    // checksum wrap over 300 bytes
    do_clear();
    we = 1'b1; dataEncoded = 8'hFF;
    for (int i = 0; i < 300; i++) tick();
    we = 1'b0;
    finish_stream();
    check_val("wrap_count", 32'(byte_count), 32'd300);
    check_val("wrap_csum", 32'(checksum), 32'h2AD4);
    check_val("wrap_ovf", 32'(overflow), 32'd0);
    read_chk("wrap_rd299", 15'd299, 8'hFF);

    // DEPTH=4 instance: fill, overflow, out-of-range read
    s_we = 1'b1; s_data = 8'hFF;
    for (int i = 0; i < 4; i++) tick();
    check_val("s_full_count", 32'(s_byte_count), 32'd4);
    check_val("s_full_ovf", 32'(s_overflow), 32'd0);
    tick(); tick();
    s_we = 1'b0;
    check_val("s_ovf_count", 32'(s_byte_count), 32'd4);
    check_val("s_ovf_csum", 32'(s_checksum), 32'h03FC);
    check_val("s_ovf_flag", 32'(s_overflow), 32'd1);
    s_finallydone = 1'b1; tick(); s_finallydone = 1'b0;
    check_val("s_done", 32'(s_capture_done), 32'd1);
    check_val("s_ovf_held", 32'(s_overflow), 32'd1);
    s_read_chk("s_rd4", 3'd4, 8'h00);
    s_read_chk("s_rd3", 3'd3, 8'hFF);
    s_clear = 1'b1; tick(); s_clear = 1'b0;
    check_val("s_clr_ovf", 32'(s_overflow), 32'd0);
    check_val("s_clr_rdata", 32'(s_rd_data), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
